// File: rtl/mac_job_scheduler.sv
// mac_job_scheduler
//   Feeds 9-element image/weight windows into a fixed-latency FP MAC pipeline, one job at a time.
//   A window is issued only when the result FIFO is guaranteed to have room for its result.
//   A shift register of tags marks which pipeline slots carry real samples.
//   Results are captured into a first-word-fall-through FIFO. The job ends when every result
//   has been popped.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start, job_len,           job start pulse (sampled only in IDLE), window count and
//   exp_bias_cfg              exponent bias, both latched on start
//   busy, done                busy in RUN/DRAIN; done pulses for one cycle at job end
//   in_valid/in_ready,        window handshake and its operands
//   in_image, in_weight
//   mac_image, mac_weight,    operands to the MAC (zero bubble when nothing fires), job bias
//   mac_exp_bias
//   mac_out                   MAC result, valid LATENCY edges after capture
//   out_valid/out_ready,      FIFO head handshake, head data, and a flag marking the last
//   out_data, out_last        result of the job
//
// Build option
//   MAC_STATS_EN  adds stall_cycles[15:0]. It counts RUN cycles with in_valid=1 and
//                 in_ready=0, saturating at 16'hFFFF, and is cleared on start and rst.

module mac_job_scheduler #(
  parameter int unsigned LATENCY    = 5,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] job_len,
  input  logic [4:0]       exp_bias_cfg,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [71:0]      in_image,
  input  logic [35:0]      in_weight,
  output logic [71:0]      mac_image,
  output logic [35:0]      mac_weight,
  output logic [4:0]       mac_exp_bias,
  input  logic [15:0]      mac_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_last
`ifdef MAC_STATS_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Wide enough for fifo_count + inflight without overflow.
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e             state_q;
  logic               busy_q, done_q;
  logic [LEN_W-1:0]   len_q, issued_q, popped_q;
  logic [4:0]         exp_bias_q;
  logic [LATENCY-1:0] tag_q;

  logic [15:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   fifo_count_q;

  logic [CNT_W-1:0]   inflight;
  logic               start_acc, fire, push, pop;

  // Every in-flight tag is a result that will land in the FIFO, so it holds a credit.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + CNT_W'(tag_q[i]);
    end
  end

  assign start_acc = (state_q == StIdle) && start;
  assign in_ready  = (state_q == StRun) && (issued_q < len_q) &&
                     ((fifo_count_q + inflight) < CNT_W'(FIFO_DEPTH));
  assign fire      = in_valid && in_ready;
  assign push      = tag_q[LATENCY-1];
  assign out_valid = (fifo_count_q != '0);
  assign pop       = out_valid && out_ready;

  assign mac_image    = fire ? in_image  : '0;
  assign mac_weight   = fire ? in_weight : '0;
  assign mac_exp_bias = exp_bias_q;

  assign out_data = mem_q[rd_ptr_q];
  assign out_last = out_valid && (popped_q == len_q - LEN_W'(1));
  assign busy     = busy_q;
  assign done     = done_q;

  // Job FSM with registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      len_q      <= '0;
      exp_bias_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            len_q      <= job_len;
            exp_bias_q <= exp_bias_cfg;
            if (job_len != '0) begin
              state_q <= StRun;
              busy_q  <= 1'b1;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (fire && (issued_q == len_q - LEN_W'(1))) state_q <= StDrain;
        end
        StDrain: begin
          if (popped_q == len_q) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Job counters.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      issued_q <= '0;
      popped_q <= '0;
    end else begin
      if (fire) issued_q <= issued_q + LEN_W'(1);
      if (pop)  popped_q <= popped_q + LEN_W'(1);
    end
  end

  // Tag shift register. It never stalls, which matches the MAC pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
    end else if (LATENCY > 1) begin
      tag_q <= {tag_q[LATENCY-2:0], fire};
    end else begin
      tag_q <= LATENCY'(fire);
    end
  end

  // FIFO storage has no reset; validity comes from fifo_count_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= mac_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + CNT_W'(1);
        2'b01:   fifo_count_q <= fifo_count_q - CNT_W'(1);
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

`ifdef MAC_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      stall_q <= '0;
    end else if ((state_q == StRun) && in_valid && !in_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule
